// File: rtl/axi4_sram_initiator_if.sv
// AXI4 interface bundle for a single-beat initiator.
// Carries the AW, W, B, AR and R channels; master/slave modports.
// Widths: ADDR_W (address), DATA_W (data, strobe = DATA_W/8), ID_W (AxID).
interface axi4_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = 4
);
   // write address channel
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awlock;
   logic [3:0]          awcache;
   logic [2:0]          awprot;
   logic [3:0]          awqos;
   logic [3:0]          awregion;
   logic                awvalid;
   logic                awready;
   // write data channel
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   // write response channel
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   // read address channel
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arlock;
   logic [3:0]          arcache;
   logic [2:0]          arprot;
   logic [3:0]          arqos;
   logic [3:0]          arregion;
   logic                arvalid;
   logic                arready;
   // read data channel
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi4_sram_initiator.sv
// Single-outstanding AXI4 initiator: turns a simple valid/ready request
// (one word read or write) into a single-beat AXI4 transaction and returns
// a one-cycle completion pulse.
// Ports: ACLK/ARESETn; req_* request side (req_ready high only when idle);
// rsp_valid/rsp_rdata/rsp_err completion side; m = AXI4 master port.
module axi4_sram_initiator #(
   parameter int unsigned             AXI_ADDRESS_WIDTH = 32,
   parameter int unsigned             AXI_DATA_WIDTH    = 32,
   parameter int unsigned             AXI_ID_WIDTH      = 4,
   parameter logic [AXI_ID_WIDTH-1:0] TXN_ID            = '0
) (
   input  logic                          ACLK,
   input  logic                          ARESETn,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [AXI_ADDRESS_WIDTH-1:0]  req_addr,
   input  logic [AXI_DATA_WIDTH-1:0]     req_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   req_wstrb,
   output logic                          rsp_valid,
   output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic                          rsp_err,
   axi4_if.master                        m
);

   localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
   localparam int unsigned SIZE   = $clog2(STRB_W);
   localparam logic [AXI_ADDRESS_WIDTH-1:0] ADDR_MASK = ~AXI_ADDRESS_WIDTH'(STRB_W - 1);

   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;

   state_t                         state_q, state_d;
   logic [AXI_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [AXI_DATA_WIDTH-1:0]      wdata_q, wdata_d;
   logic [STRB_W-1:0]              wstrb_q, wstrb_d;
   logic                           aw_done_q, aw_done_d;
   logic                           w_done_q, w_done_d;
   logic                           awvalid_q, awvalid_d;
   logic                           wvalid_q, wvalid_d;
   logic                           bready_q, bready_d;
   logic                           arvalid_q, arvalid_d;
   logic                           rready_q, rready_d;
   logic                           ready_q, ready_d;
   logic                           rsp_valid_q, rsp_valid_d;
   logic                           rsp_err_q, rsp_err_d;
   logic [AXI_DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;

   // State and registered outputs
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Next state, capture and completion; channel strobes are decoded from
   // the next state so they come straight out of flops.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               state_d = req_write ? WR_AW_W : RD_AR;
            end
         end
         WR_AW_W: begin
            if (awvalid_q && m.awready) aw_done_d = 1'b1;
            if (wvalid_q && m.wready)   w_done_d  = 1'b1;
            // AW and W may complete in either order or together
            if (aw_done_d && w_done_d) begin
               state_d   = WR_B;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         WR_B: begin
            if (m.bvalid) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = (m.bresp != 2'b00);
            end
         end
         RD_AR: begin
            if (m.arready) state_d = RD_R;
         end
         RD_R: begin
            if (m.rvalid) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = (m.rresp != 2'b00);
               rsp_rdata_d = m.rdata;
            end
         end
         default: state_d = IDLE;
      endcase

      awvalid_d = (state_d == WR_AW_W) && !aw_done_d;
      wvalid_d  = (state_d == WR_AW_W) && !w_done_d;
      bready_d  = (state_d == WR_B);
      arvalid_d = (state_d == RD_AR);
      rready_d  = (state_d == RD_R);
      ready_d   = (state_d == IDLE);
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

   // Write address channel: single beat, word aligned
   assign m.awid     = TXN_ID;
   assign m.awaddr   = addr_q & ADDR_MASK;
   assign m.awlen    = 8'd0;
   assign m.awsize   = 3'(SIZE);
   assign m.awburst  = 2'b01;
   assign m.awlock   = 1'b0;
   assign m.awcache  = 4'd0;
   assign m.awprot   = 3'd0;
   assign m.awqos    = 4'd0;
   assign m.awregion = 4'd0;
   assign m.awvalid  = awvalid_q;

   // Write data channel; an all-zero strobe is passed through unchanged
   assign m.wdata    = wdata_q;
   assign m.wstrb    = wstrb_q;
   assign m.wlast    = 1'b1;
   assign m.wvalid   = wvalid_q;

   assign m.bready   = bready_q;

   // Read address channel
   assign m.arid     = TXN_ID;
   assign m.araddr   = addr_q & ADDR_MASK;
   assign m.arlen    = 8'd0;
   assign m.arsize   = 3'(SIZE);
   assign m.arburst  = 2'b01;
   assign m.arlock   = 1'b0;
   assign m.arcache  = 4'd0;
   assign m.arprot   = 3'd0;
   assign m.arqos    = 4'd0;
   assign m.arregion = 4'd0;
   assign m.arvalid  = arvalid_q;

   assign m.rready   = rready_q;

endmodule
